// File: rtl/vga_pkg.sv
// vga_pkg: pattern mode encodings, colour-bar table and default 640x480 timing.
package vga_pkg;
  typedef enum logic [1:0] {MODE_SOLID, MODE_BARS, MODE_CHECK, MODE_BAR} mode_e;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  // {R,G,B} on/off flags: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [2:0] BAR_RGB [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                         3'b101, 3'b100, 3'b001, 3'b000};
endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel/line counters with visible and sync decode plus frame markers.
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CNT_W    = 10
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_pix_en,
  output logic [CNT_W-1:0] o_hc,
  output logic [CNT_W-1:0] o_vc,
  output logic             o_visible,
  output logic             o_hsync_act,
  output logic             o_vsync_act,
  output logic             o_origin,
  output logic             o_frame_wrap
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  logic [CNT_W-1:0] r_hc, r_vc;
  logic w_h_end, w_v_end;
  assign w_h_end = r_hc == CNT_W'(H_TOTAL - 1);
  assign w_v_end = r_vc == CNT_W'(V_TOTAL - 1);
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (i_pix_en) begin
      r_hc <= w_h_end ? '0 : r_hc + 1'b1;
      if (w_h_end) r_vc <= w_v_end ? '0 : r_vc + 1'b1;
    end
  end
  assign o_hc         = r_hc;
  assign o_vc         = r_vc;
  assign o_visible    = r_hc < CNT_W'(H_ACTIVE) && r_vc < CNT_W'(V_ACTIVE);
  assign o_hsync_act  = r_hc >= CNT_W'(H_ACTIVE + H_FP) && r_hc < CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  assign o_vsync_act  = r_vc >= CNT_W'(V_ACTIVE + V_FP) && r_vc < CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  assign o_origin     = r_hc == '0 && r_vc == '0;
  assign o_frame_wrap = w_h_end && w_v_end;
endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: VGA timing plus solid/bars/checker/moving-bar test patterns, registered outputs.
// Define VGA_PATTERN_BORDER_EN to force a white one-pixel border around the visible area.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int COLOR_W  = 3,
  parameter int CNT_W    = 10
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_pix_en,
  input  logic [1:0]           i_mode,
  input  logic [3*COLOR_W-1:0] i_solid_color,
  output logic                 o_hsync,
  output logic                 o_vsync,
  output logic                 o_video_enable,
  output logic [CNT_W-1:0]     o_pixel_x,
  output logic [CNT_W-1:0]     o_pixel_y,
  output logic [3*COLOR_W-1:0] o_rgb,
  output logic                 o_frame_start
);
  localparam int RGB_W = 3 * COLOR_W;
  localparam logic [RGB_W-1:0] WHITE = '1;
  logic [CNT_W-1:0] w_hc, w_vc;
  logic w_visible, w_hsync_act, w_vsync_act, w_origin, w_frame_wrap;
  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .CNT_W(CNT_W)
  ) u_timing (
    .i_clock(i_clock), .i_reset(i_reset), .i_pix_en(i_pix_en),
    .o_hc(w_hc), .o_vc(w_vc), .o_visible(w_visible),
    .o_hsync_act(w_hsync_act), .o_vsync_act(w_vsync_act),
    .o_origin(w_origin), .o_frame_wrap(w_frame_wrap)
  );
  mode_e r_mode, w_mode;
  logic [CNT_W-1:0] r_bar_pos, w_bar_next;
  logic [CNT_W:0] w_hc_x, w_bar_lo, w_bar_sum;
  logic w_in_bar, w_border;
  logic [2:0] w_bar_idx, w_flags;
  logic [RGB_W-1:0] w_bar_rgb, w_pattern, w_rgb;
  logic r_hsync, r_vsync, r_video_enable, r_frame_start;
  logic [CNT_W-1:0] r_pixel_x, r_pixel_y;
  logic [RGB_W-1:0] r_rgb;
  // The frame being started uses the incoming mode, so the whole frame is consistent.
  assign w_mode = w_origin ? mode_e'(i_mode) : r_mode;
  always_comb begin
    w_bar_idx = '0;
    for (int k = 1; k < 8; k++)
      if (w_hc >= CNT_W'(k * H_ACTIVE / 8)) w_bar_idx = 3'(k);
  end
  assign w_flags   = BAR_RGB[w_bar_idx];
  assign w_bar_rgb = {{COLOR_W{w_flags[2]}}, {COLOR_W{w_flags[1]}}, {COLOR_W{w_flags[0]}}};
  assign w_hc_x    = (CNT_W+1)'(w_hc);
  assign w_bar_lo  = (CNT_W+1)'(r_bar_pos);
  assign w_in_bar  = w_hc_x >= w_bar_lo && w_hc_x < w_bar_lo + (CNT_W+1)'(16);
  assign w_bar_sum = w_bar_lo + (CNT_W+1)'(4);
  assign w_bar_next = CNT_W'(w_bar_sum >= (CNT_W+1)'(H_ACTIVE) ? w_bar_sum - (CNT_W+1)'(H_ACTIVE) : w_bar_sum);
  always_comb
    w_pattern = w_mode == MODE_SOLID ? i_solid_color :
                w_mode == MODE_BARS  ? w_bar_rgb :
                w_mode == MODE_CHECK ? ((w_hc[5] ^ w_vc[5]) ? WHITE : '0) :
                (w_in_bar ? WHITE : '0);
`ifdef VGA_PATTERN_BORDER_EN
  assign w_border = w_hc == '0 || w_hc == CNT_W'(H_ACTIVE - 1) ||
                    w_vc == '0 || w_vc == CNT_W'(V_ACTIVE - 1);
`else
  assign w_border = 1'b0;
`endif
  assign w_rgb = !w_visible ? '0 : w_border ? WHITE : w_pattern;
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_mode         <= MODE_SOLID;
      r_bar_pos      <= '0;
      r_hsync        <= ~SYNC_POL;
      r_vsync        <= ~SYNC_POL;
      r_video_enable <= 1'b0;
      r_pixel_x      <= '0;
      r_pixel_y      <= '0;
      r_rgb          <= '0;
      r_frame_start  <= 1'b0;
    end else begin
      r_frame_start <= i_pix_en && w_origin;
      if (i_pix_en) begin
        r_hsync        <= w_hsync_act ? SYNC_POL : ~SYNC_POL;
        r_vsync        <= w_vsync_act ? SYNC_POL : ~SYNC_POL;
        r_video_enable <= w_visible;
        r_pixel_x      <= w_hc;
        r_pixel_y      <= w_vc;
        r_rgb          <= w_rgb;
        if (w_origin) r_mode <= mode_e'(i_mode);
        if (w_frame_wrap) r_bar_pos <= w_bar_next;
      end
    end
  end
  assign o_hsync        = r_hsync;
  assign o_vsync        = r_vsync;
  assign o_video_enable = r_video_enable;
  assign o_pixel_x      = r_pixel_x;
  assign o_pixel_y      = r_pixel_y;
  assign o_rgb          = r_rgb;
  assign o_frame_start  = r_frame_start;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: scoreboarded bench on a scaled-down raster (44x34 visible, 52x38 total).
module tb_vga_pattern_gen;
  localparam int HA = 44, HF = 2, HS = 4, HB = 2;
  localparam int VA = 34, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB;
  typedef struct packed {
    logic hs; logic vs; logic ve;
    logic [9:0] x; logic [9:0] y;
    logic [8:0] rgb; logic fs;
  } out_t;
  logic clk = 0, rst = 1, pix_en = 0;
  logic [1:0] mode = 0;
  logic [8:0] solid = 9'b011010101;
  logic hs, vs, ve, fs;
  logic [9:0] px, py;
  logic [8:0] rgb;
  out_t q[$];
  out_t obs, e;
  int checks = 0, failures = 0;
  int m_hc = 0, m_vc = 0, m_bar = 0;
  logic [1:0] m_mode = 0;
  logic [8:0] bars [8] = '{9'h1FF, 9'h1F8, 9'h03F, 9'h038, 9'h1C7, 9'h1C0, 9'h007, 9'h000};

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .COLOR_W(3), .CNT_W(10)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_pix_en(pix_en), .i_mode(mode),
    .i_solid_color(solid), .o_hsync(hs), .o_vsync(vs), .o_video_enable(ve),
    .o_pixel_x(px), .o_pixel_y(py), .o_rgb(rgb), .o_frame_start(fs)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] ref_rgb(int x, int y, logic [1:0] md, int bar);
    logic [8:0] c;
    int idx;
    if (x >= HA || y >= VA) return 9'h000;
    idx = 0;
    for (int k = 0; k < 8; k++) if (x >= (k * HA) / 8) idx = k;
    case (md)
      2'd0: c = solid;
      2'd1: c = bars[idx];
      2'd2: c = (((x / 32) + (y / 32)) % 2 == 1) ? 9'h1FF : 9'h000;
      default: c = (x >= bar && x < bar + 16) ? 9'h1FF : 9'h000;
    endcase
`ifdef VGA_PATTERN_BORDER_EN
    if (x == 0 || x == HA - 1 || y == 0 || y == VA - 1) c = 9'h1FF;
`endif
    return c;
  endfunction

  task automatic model_reset();
    m_hc = 0; m_vc = 0; m_bar = 0; m_mode = 0;
    q.delete();
  endtask

  task automatic model_strobe();
    out_t x;
    logic [1:0] md;
    md = (m_hc == 0 && m_vc == 0) ? mode : m_mode;
    if (m_hc == 0 && m_vc == 0) m_mode = mode;
    x.x = 10'(m_hc); x.y = 10'(m_vc);
    x.ve = m_hc < HA && m_vc < VA;
    x.hs = !(m_hc >= HA + HF && m_hc < HA + HF + HS);
    x.vs = !(m_vc >= VA + VF && m_vc < VA + VF + VS);
    x.rgb = ref_rgb(m_hc, m_vc, md, m_bar);
    x.fs = m_hc == 0 && m_vc == 0;
    q.push_back(x);
    if (m_hc == HT - 1) begin
      m_hc = 0;
      if (m_vc == VT - 1) begin
        m_vc = 0;
        m_bar += 4;
        if (m_bar >= HA) m_bar -= HA;
      end else m_vc++;
    end else m_hc++;
  endtask

  task automatic step(input int gap);
    repeat (gap - 1) begin pix_en = 0; @(posedge clk); #1; end
    pix_en = 1;
    model_strobe();
    @(posedge clk); #1;
    pix_en = 0;
    obs = {hs, vs, ve, px, py, rgb, fs};
  endtask

  task automatic test_reset();
    out_t r;
    rst = 1; pix_en = 1;
    repeat (3) @(posedge clk);
    #1;
    r = {hs, vs, ve, px, py, rgb, fs};
    checks++;
    if (r !== {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 9'd0, 1'b0}) begin
      failures++; $display("FAIL reset_state got=%h exp=%h", r, {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 9'd0, 1'b0});
    end
    pix_en = 0; rst = 0;
    model_reset();
  endtask

  task automatic test_timing();
    int h_start = -1, h_len = 0, run = 0, last_x0 = -1, pmin = 1 << 30, pmax = 0;
    int vmin = 1 << 30, vmax = -1, fs0 = -1, fs1 = -1;
    bit in_low = 0;
    out_t held;
    mode = 0;
    for (int i = 0; i <= HT * VT; i++) begin
      step(4);
      e = q.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL timing_pixel got=%h exp=%h", obs, e); end
      if (i == 0) begin
        @(posedge clk); #1;
        held = {hs, vs, ve, px, py, rgb, fs};
        checks++;
        if (held !== {e.hs, e.vs, e.ve, e.x, e.y, e.rgb, 1'b0}) begin
          failures++; $display("FAIL hold_no_strobe got=%h exp=%h", held, {e.hs, e.vs, e.ve, e.x, e.y, e.rgb, 1'b0});
        end
      end
      if (obs.hs === 1'b0) begin
        if (!in_low) begin in_low = 1; run = 0; if (h_start < 0) h_start = int'(obs.x); end
        run++;
      end else if (in_low) begin
        in_low = 0;
        if (h_len == 0) h_len = run;
      end
      if (obs.x == 0) begin
        if (last_x0 >= 0) begin
          if (i - last_x0 < pmin) pmin = i - last_x0;
          if (i - last_x0 > pmax) pmax = i - last_x0;
        end
        last_x0 = i;
      end
      if (obs.vs === 1'b0) begin
        if (int'(obs.y) < vmin) vmin = int'(obs.y);
        if (int'(obs.y) > vmax) vmax = int'(obs.y);
      end
      if (obs.fs === 1'b1) begin if (fs0 < 0) fs0 = i; else if (fs1 < 0) fs1 = i; end
      if ((obs.x == 1 && obs.y == 1) || (obs.x == HA - 1 && obs.y == VA - 1)) begin
        checks++;
        if (obs.rgb !== 9'b011010101) begin failures++; $display("FAIL solid_visible got=%h exp=%h", obs.rgb, 9'b011010101); end
      end
      if ((obs.x == HA && obs.y == 0) || (obs.x == 0 && obs.y == VA)) begin
        checks++;
        if (obs.rgb !== 9'h000 || obs.ve !== 1'b0) begin failures++; $display("FAIL solid_blank got=%h ve=%b exp=000 ve=0", obs.rgb, obs.ve); end
      end
    end
    checks++;
    if (h_start != HA + HF || h_len != HS) begin failures++; $display("FAIL hsync_window got start=%0d len=%0d exp start=%0d len=%0d", h_start, h_len, HA + HF, HS); end
    checks++;
    if (pmin != HT || pmax != HT) begin failures++; $display("FAIL line_period got min=%0d max=%0d exp=%0d", pmin, pmax, HT); end
    checks++;
    if (vmin != VA + VF || vmax != VA + VF + VS - 1) begin failures++; $display("FAIL vsync_lines got=%0d..%0d exp=%0d..%0d", vmin, vmax, VA + VF, VA + VF + VS - 1); end
    checks++;
    if (fs0 != 0 || fs1 - fs0 != HT * VT) begin failures++; $display("FAIL frame_period got=%0d exp=%0d", fs1 - fs0, HT * VT); end
  endtask

  task automatic test_bars();
    int frames = 0;
    logic [8:0] want;
    mode = 1;
    for (int i = 0; i < 3 * HT * VT && frames < 2; i++) begin
      step(1);
      e = q.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL bars_pixel got=%h exp=%h", obs, e); end
      if (obs.fs === 1'b1) frames++;
      if (frames == 0 && obs.ve === 1'b1 && obs.x == 20 && obs.y == 20) begin
        checks++;
        if (obs.rgb !== solid) begin failures++; $display("FAIL mode_midframe got=%h exp=%h", obs.rgb, solid); end
      end
      if (frames == 1 && obs.y == 2 && (obs.x == 0 || obs.x == 5 || obs.x == 37 || obs.x == 38 || obs.x == HA - 1)) begin
        want = obs.x == 0 ? 9'h1FF : obs.x == 5 ? 9'b111111000 : obs.x == 37 ? 9'h007 : 9'h000;
        checks++;
        if (obs.rgb !== want) begin failures++; $display("FAIL bars_x%0d got=%h exp=%h", obs.x, obs.rgb, want); end
      end
    end
  endtask

  task automatic test_checker();
    int frames = 0;
    logic [8:0] want;
    mode = 2;
    for (int i = 0; i < 3 * HT * VT && frames < 2; i++) begin
      step(1);
      e = q.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL checker_pixel got=%h exp=%h", obs, e); end
      if (obs.fs === 1'b1) frames++;
      if (frames == 1 && (obs.x == 31 || obs.x == 32 || obs.x == 1) && (obs.y == 1 || obs.y == 32)) begin
        want = ((obs.x >= 32) != (obs.y >= 32)) ? 9'h1FF : 9'h000;
        checks++;
        if (obs.rgb !== want) begin failures++; $display("FAIL checker_%0d_%0d got=%h exp=%h", obs.x, obs.y, obs.rgb, want); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    out_t r;
    bit hit = 0;
    mode = 0;
    for (int i = 0; i < 2 * HT * VT && !hit; i++) begin
      step(1);
      e = q.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL prereset_pixel got=%h exp=%h", obs, e); end
      hit = obs.x == 30 && obs.y == 20;
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL reach_30_20 got=%0d,%0d exp=30,20", obs.x, obs.y); end
    rst = 1; pix_en = 1;
    @(posedge clk); #1;
    rst = 0; pix_en = 0;
    model_reset();
    r = {hs, vs, ve, px, py, rgb, fs};
    checks++;
    if (r !== {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 9'd0, 1'b0}) begin failures++; $display("FAIL midframe_reset got=%h exp=%h", r, {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 9'd0, 1'b0}); end
    step(1);
    e = q.pop_front();
    checks++;
    if (obs !== {1'b1, 1'b1, 1'b1, 10'd0, 10'd0, solid, 1'b1}) begin failures++; $display("FAIL after_reset_origin got=%h exp=%h", obs, {1'b1, 1'b1, 1'b1, 10'd0, 10'd0, solid, 1'b1}); end
    checks++;
    if (obs !== e) begin failures++; $display("FAIL after_reset_model got=%h exp=%h", obs, e); end
  endtask

  task automatic test_moving_bar();
    int frames = 0, first = -1, last = -1, exp_s, exp_e;
    rst = 1; pix_en = 0;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    mode = 3;
    for (int i = 0; i < 14 * HT * VT && frames < 13; i++) begin
      step(1);
      e = q.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL bar_pixel got=%h exp=%h", obs, e); end
      if (obs.fs === 1'b1) frames++;
      if (obs.y == 1) begin
        if (obs.x == 0) begin first = -1; last = -1; end
        if (obs.rgb === 9'h1FF) begin if (first < 0) first = int'(obs.x); last = int'(obs.x); end
        if (obs.x == HT - 1) begin
          exp_s = (4 * (frames - 1)) % HA;
          exp_e = exp_s + 15 > HA - 1 ? HA - 1 : exp_s + 15;
          checks++;
          if (first != exp_s || last != exp_e) begin failures++; $display("FAIL bar_span_f%0d got=%0d..%0d exp=%0d..%0d", frames - 1, first, last, exp_s, exp_e); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_bars();
    test_checker();
    test_reset_midframe();
    test_moving_bar();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
